// File: rtl/sprite_animator.sv
// Sprite animation engine: frame sequencing per animation plus a 3-stage pixel pipeline that
// maps a scanned OLED pixel to a sprite-ROM address and returns a tinted, colour-keyed pixel.
module sprite_animator #(
  parameter int unsigned SCR_W      = 96,
  parameter int unsigned SCR_H      = 64,
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned NUM_ANIMS  = 8,
  parameter int unsigned MAX_FRAMES = 4,
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter logic [15:0] KEY_COLOUR = 16'hFFFF,
  parameter logic [15:0] BG_COLOUR  = 16'hFFFF,
  parameter int unsigned ADDR_W     = 15,
  localparam int unsigned SelW = (NUM_ANIMS > 1) ? $clog2(NUM_ANIMS) : 1,
  localparam int unsigned FrmW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1,
  localparam int unsigned LenW = FrmW + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [SelW-1:0]   anim_sel_i,
  input  logic [LenW-1:0]   anim_len_i,
  input  logic              anim_loop_i,
  input  logic [6:0]        x_i,
  input  logic [6:0]        y_i,
  input  logic              mirror_i,
  input  logic [1:0]        tint_mode_i,
  input  logic [12:0]       pixel_index_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic [15:0]       oled_colour_o,
  output logic [FrmW-1:0]   frame_idx_o,
  output logic              anim_busy_o,
  output logic              anim_done_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Sequencer state
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] prev_sel_q;
  logic [FrmW-1:0] frame_q, frame_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            flash_q, flash_d;
  logic            tick;
  logic [LenW-1:0] eff_len;
  logic            sel_change;
  logic            at_last;

  // Display latch and pixel pipeline state
  logic [SelW-1:0]   disp_anim_q, disp_anim_d;
  logic [FrmW-1:0]   disp_frame_q, disp_frame_d;
  logic [8:0]        col9, row9, lx_raw, lx, ly;
  logic              in_bounds;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inb1_q, inb2_q;
  logic [1:0]        tint1_q, tint2_q;
  logic              flash1_q, flash2_q;
  logic [15:0]       colour_q, colour_d;

  assign tick       = (cnt_q == CntW'(TICK_DIV - 1));
  assign sel_change = (anim_sel_i != prev_sel_q);

  always_comb begin
    eff_len = anim_len_i;
    if (anim_len_i == '0) begin
      eff_len = LenW'(1);
    end else if (anim_len_i > LenW'(MAX_FRAMES)) begin
      eff_len = LenW'(MAX_FRAMES);
    end
  end

  assign at_last = (LenW'(frame_q) == eff_len - LenW'(1));

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flash_d = flash_q;
    if (sel_change) begin
      cnt_d   = '0;
      frame_d = '0;
      busy_d  = !anim_loop_i;
    end else begin
      if (LenW'(frame_q) >= eff_len) begin
        frame_d = '0;
      end else if (tick) begin
        if (anim_loop_i) begin
          frame_d = at_last ? '0 : frame_q + FrmW'(1);
        end else if (busy_q) begin
          if (at_last) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            frame_d = frame_q + FrmW'(1);
          end
        end
      end
      if (tick) begin
        flash_d = !flash_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      prev_sel_q <= anim_sel_i;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flash_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prev_sel_q <= anim_sel_i;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flash_q    <= flash_d;
    end
  end

  // Pixel 0 starts a new OLED frame; it already uses the freshly latched animation/frame.
  always_comb begin
    disp_anim_d  = disp_anim_q;
    disp_frame_d = disp_frame_q;
    if (pixel_index_i == '0) begin
      disp_anim_d  = anim_sel_i;
      disp_frame_d = frame_q;
    end
  end

  // 9-bit two's complement: negative local coordinates wrap above 255 and fail the bound test.
  always_comb begin
    col9      = 9'(pixel_index_i % 13'(SCR_W));
    row9      = 9'(pixel_index_i / 13'(SCR_W));
    lx_raw    = col9 - {2'b00, x_i} + 9'(SPR_W / 2);
    ly        = row9 - {2'b00, y_i} + 9'(SPR_H / 2);
    lx        = mirror_i ? 9'(SPR_W - 1) - lx_raw : lx_raw;
    in_bounds = (lx < 9'(SPR_W)) && (ly < 9'(SPR_H));
    rom_addr_d = '0;
    if (in_bounds) begin
      rom_addr_d = ((ADDR_W'(disp_anim_d) * ADDR_W'(MAX_FRAMES) + ADDR_W'(disp_frame_d))
                    * ADDR_W'(SPR_H) + ADDR_W'(ly)) * ADDR_W'(SPR_W) + ADDR_W'(lx);
    end
  end

  always_comb begin
    colour_d = rom_data_i;
    if (!inb2_q) begin
      colour_d = BG_COLOUR;
    end else if (rom_data_i == KEY_COLOUR) begin
      colour_d = KEY_COLOUR;
    end else begin
      case (tint2_q)
        2'b01:   colour_d = {rom_data_i[15:11], 1'b0, rom_data_i[10:6], rom_data_i[4:0]};
        2'b10:   colour_d = ~rom_data_i;
        2'b11:   colour_d = flash2_q ? 16'hFFFF : rom_data_i;
        default: colour_d = rom_data_i;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_anim_q  <= '0;
      disp_frame_q <= '0;
      rom_addr_q   <= '0;
      inb1_q       <= 1'b0;
      tint1_q      <= 2'b00;
      flash1_q     <= 1'b0;
      inb2_q       <= 1'b0;
      tint2_q      <= 2'b00;
      flash2_q     <= 1'b0;
      colour_q     <= BG_COLOUR;
    end else begin
      disp_anim_q  <= disp_anim_d;
      disp_frame_q <= disp_frame_d;
      rom_addr_q   <= rom_addr_d;
      inb1_q       <= in_bounds;
      tint1_q      <= tint_mode_i;
      flash1_q     <= flash_q;
      inb2_q       <= inb1_q;
      tint2_q      <= tint1_q;
      flash2_q     <= flash1_q;
      colour_q     <= colour_d;
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign oled_colour_o = colour_q;
  assign frame_idx_o   = frame_q;
  assign anim_busy_o   = busy_q;
  assign anim_done_o   = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: frame sequencing, pixel address mapping, tint and flush.
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  anim_sel;
  logic [2:0]  anim_len;
  logic        anim_loop;
  logic [6:0]  x, y;
  logic        mirror;
  logic [1:0]  tint_mode;
  logic [12:0] pixel_index;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] oled_colour;
  logic [1:0]  frame_idx;
  logic        anim_busy, anim_done;

  logic        rom_force;
  logic [15:0] rom_force_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ROM model: returns its own address unless a forced word is selected.
  always_ff @(posedge clk) begin
    rom_data <= rom_force ? rom_force_val : {1'b0, rom_addr};
  end

  sprite_animator #(
    .TICK_DIV (4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .anim_sel_i    (anim_sel),
    .anim_len_i    (anim_len),
    .anim_loop_i   (anim_loop),
    .x_i           (x),
    .y_i           (y),
    .mirror_i      (mirror),
    .tint_mode_i   (tint_mode),
    .pixel_index_i (pixel_index),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .oled_colour_o (oled_colour),
    .frame_idx_o   (frame_idx),
    .anim_busy_o   (anim_busy),
    .anim_done_o   (anim_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic done_seen;
    reset = 1'b1; anim_sel = 3'd2; anim_len = 3'd3; anim_loop = 1'b1;
    x = 7'd48; y = 7'd32; mirror = 1'b0; tint_mode = 2'b00; pixel_index = 13'd1;
    rom_force = 1'b0; rom_force_val = 16'h0000;
    step();
    step();
    check("rst_colour", oled_colour, 16'hFFFF);
    check("rst_addr", rom_addr, 0);
    check("rst_frame", frame_idx, 0);
    check("rst_busy", anim_busy, 0);
    check("rst_done", anim_done, 0);

    // Loop mode, len 3: frame advances every 4 clocks
    reset = 1'b0;
    done_seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("loop_frame", frame_idx, (k / 4) % 3);
      done_seen = done_seen | anim_done;
    end
    check("loop_no_done", done_seen, 0);

    // One-shot 0..2 then done pulse 12 clocks after switch
    anim_sel = 3'd5; anim_loop = 1'b0;
    step();
    check("os_start_frame", frame_idx, 0);
    check("os_start_busy", anim_busy, 1);
    for (int k = 1; k <= 14; k++) begin
      step();
      check("os_frame", frame_idx, (k < 4) ? 0 : (k < 8) ? 1 : 2);
      check("os_done", anim_done, (k == 12) ? 1 : 0);
      check("os_busy", anim_busy, (k < 12) ? 1 : 0);
    end

    // One-shot interrupted at frame 1
    anim_sel = 3'd1;
    step();
    for (int k = 1; k <= 6; k++) step();
    check("int_pre_frame", frame_idx, 1);
    anim_sel = 3'd3;
    step();
    check("int_frame", frame_idx, 0);
    check("int_busy", anim_busy, 1);
    check("int_done", anim_done, 0);
    done_seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      done_seen = done_seen | anim_done;
      if (k == 3) check("int_restart3", frame_idx, 0);
      if (k == 4) check("int_restart4", frame_idx, 1);
    end
    check("int_no_done", done_seen, 0);

    // Address mapping at sprite centre, normal then mirrored
    anim_sel = 3'd2; anim_loop = 1'b1; anim_len = 3'd3;
    step();
    pixel_index = 13'd0;
    step();
    pixel_index = 13'd3120; mirror = 1'b0;
    step();
    check("ctr_addr", rom_addr, 15'd8720);
    mirror = 1'b1;
    step();
    check("ctr_addr_mir", rom_addr, 15'd8719);
    step();
    check("ctr_colour", oled_colour, 16'd8720);
    step();
    check("ctr_colour_mir", oled_colour, 16'd8719);

    // Clipping with x=80, y=10
    anim_sel = 3'd4; anim_loop = 1'b0; mirror = 1'b0;
    step();
    pixel_index = 13'd0; x = 7'd80; y = 7'd10;
    step();
    check("clip_addr_p0", rom_addr, 0);
    pixel_index = 13'd95;
    step();
    check("clip_addr_p95", rom_addr, 15'd16607);
    pixel_index = 13'd96;
    step();
    check("clip_addr_p96", rom_addr, 0);
    check("clip_col_p0", oled_colour, 16'hFFFF);
    pixel_index = 13'd95;
    step();
    check("clip_col_p95", oled_colour, 16'd16607);
    step();
    check("clip_col_p96", oled_colour, 16'hFFFF);

    // Tinting on an in-bounds pixel
    rom_force = 1'b1;
    rom_force_val = 16'h07E0; tint_mode = 2'b01;
    step(); step(); step();
    check("tint_halve_g", oled_colour, 16'h03E0);
    rom_force_val = 16'hFFFF; tint_mode = 2'b10;
    step(); step(); step();
    check("tint_key", oled_colour, 16'hFFFF);
    rom_force_val = 16'h1234;
    step(); step(); step();
    check("tint_invert", oled_colour, 16'hEDCB);
    tint_mode = 2'b00;
    step(); step(); step();
    check("tint_none", oled_colour, 16'h1234);

    // Reset flushes the pipeline; flash alternates per tick afterwards
    tint_mode = 2'b11;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int m = 1; m <= 14; m++) begin
      step();
      check("flash", oled_colour,
            (m < 3) ? 16'hFFFF : ((((m - 3) / 4) % 2) != 0) ? 16'hFFFF : 16'h1234);
    end
    rom_force = 1'b0;

    // Length clamping: 7 -> 4 frames, 0 -> 1 frame
    anim_sel = 3'd6; anim_loop = 1'b1; anim_len = 3'd7;
    step();
    for (int k = 1; k <= 20; k++) begin
      step();
      check("clamp_hi", frame_idx, (k / 4) % 4);
    end
    anim_sel = 3'd7; anim_len = 3'd0;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      check("clamp_zero", frame_idx, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised sprite animation engine for the OLED fighter display. It sequences frames for any of up to NUM_ANIMS animations in loop or one-shot mode, and maps each scanned pixel_index into a sprite-ROM address using position and mirroring.
- It returns a tinted, keyed 16-bit colour with fixed pipeline latency.
- It sits between the character FSM (anim_sel, position) and the OLED layer mixer. It replaces per-state hard-coded sprite muxing with one external frame ROM.

Parameters:
SCR_W, 96, screen width in pixels
SCR_H, 64, screen height in pixels
SPR_W, 32, sprite width in pixels
SPR_H, 32, sprite height in pixels
NUM_ANIMS, 8, number of animations stored in ROM
MAX_FRAMES, 4, frame slots per animation in ROM
TICK_DIV, 12_500_000, clk cycles per animation frame (8 Hz at 100 MHz)
KEY_COLOUR, 16'hFFFF, transparent colour in ROM; never tinted
BG_COLOUR, 16'hFFFF, colour output for pixels outside the sprite
ADDR_W, 15, ROM address width; must hold NUM_ANIMS*MAX_FRAMES*SPR_W*SPR_H

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
anim_sel  in  clog2(NUM_ANIMS)  animation index
anim_len  in  clog2(MAX_FRAMES)+1  frames in the current animation; 0 is treated as 1; values above MAX_FRAMES are clamped to MAX_FRAMES
anim_loop  in  1  1 = loop, 0 = one-shot
x  in  7  sprite centre column
y  in  7  sprite centre row
mirror  in  1  horizontal flip about the sprite centre
tint_mode  in  2  00 none, 01 halve green, 10 invert RGB, 11 flash
pixel_index  in  13  scanned pixel, row*SCR_W+col
rom_addr  out  ADDR_W  registered sprite-ROM address
rom_data  in  16  ROM word; synchronous ROM with 1-cycle read latency
oled_colour  out  16  registered pixel colour
frame_idx  out  clog2(MAX_FRAMES)  current frame
anim_busy  out  1  one-shot in progress
anim_done  out  1  one-cycle pulse when a one-shot finishes

Behaviour:
Reset values:
- All registers clear on reset.
- oled_colour=BG_COLOUR, rom_addr=0, frame_idx=0, anim_busy=0, anim_done=0.
- Tick counter=0, flash phase=0. The stored previous anim_sel takes the current anim_sel value.

Tick generator:
- Counter runs 0..TICK_DIV-1.
- tick pulses for one cycle on the wrap from TICK_DIV-1 to 0.

Frame sequencer (evaluated every cycle, priority order):
1. anim_sel differs from the previous-cycle value:
   - frame_idx=0, tick counter=0, anim_done=0.
   - anim_busy=!anim_loop.
   - Any tick in this cycle is ignored.
2. frame_idx >= effective anim_len: frame_idx=0.
3. On tick, loop mode: frame_idx wraps from len-1 to 0.
4. On tick, one-shot with anim_busy=1:
   - If frame_idx<len-1, increment frame_idx.
   - Otherwise anim_done pulses and anim_busy falls. frame_idx holds the last frame until anim_sel changes.
5. On tick, flash phase toggles.
- A change of anim_loop alone does not restart the animation.

Display frame latch:
- anim_sel and frame_idx are copied into disp_anim/disp_frame only when pixel_index==0 is sampled.
- This prevents tearing within one OLED frame.

Pixel pipeline (fixed latency 3; pixel_index sampled at cycle N gives oled_colour valid at N+3):
- S1, cycle N+1:
  - col=pixel_index%SCR_W, row=pixel_index/SCR_W.
  - lx=col-x+SPR_W/2, ly=row-y+SPR_H/2, computed with signed 9-bit arithmetic.
  - If mirror=1, lx=SPR_W-1-lx.
  - in_bounds = 0<=lx<SPR_W and 0<=ly<SPR_H.
  - rom_addr = ((disp_anim*MAX_FRAMES+disp_frame)*SPR_H+ly)*SPR_W+lx. When out of bounds, rom_addr=0.
  - in_bounds, tint_mode and flash phase are registered alongside.
- S2, cycle N+2: rom_data valid; the side-band signals are delayed one more stage.
- S3, cycle N+3, oled_colour:
  - !in_bounds → BG_COLOUR.
  - rom_data==KEY_COLOUR → KEY_COLOUR.
  - Otherwise apply tint_mode:
    - 01: bits[10:5]>>1.
    - 10: ~rom_data.
    - 11: 16'hFFFF when flash phase=1, else rom_data.
    - 00: rom_data.
- A sprite partially off-screen is clipped; coordinates do not wrap around screen edges.
- Reset asserted mid-pipeline flushes all stages. The first valid colour appears 3 cycles after reset deasserts.

Test Plan:
- TICK_DIV=4, anim_loop=1, anim_len=3, anim_sel=2 → frame_idx sequence 0,1,2,0,1 changing every 4 clk; anim_done never asserts.
- TICK_DIV=4, anim_loop=0, anim_len=3, switch anim_sel 0→5 → anim_busy=1; frame_idx 0,1,2; anim_done one-cycle pulse 12 clk after the switch; frame_idx holds at 2; anim_busy=0.
- One-shot mid-run (frame 1), anim_sel changes → frame_idx=0 next cycle, anim_busy=1, tick counter restarts, no anim_done pulse.
- x=48, y=32, SPR 32x32, pixel_index=32*96+48, ROM model returning the address as data → rom_addr at N+1 = (disp offset)+16*32+16; with mirror=1, lx=15; oled_colour equals that ROM word at N+3.
- pixel_index=0 with x=80, y=10 (sprite lies partly off-screen), and pixel_index=95 → pixel 0 outputs BG_COLOUR; the sprite is clipped at the right edge with no wrap into the next row.
- rom_data=16'h07E0 with tint 01 → 16'h03E0; rom_data=KEY_COLOUR with tint 10 → KEY_COLOUR unchanged; tint 11 → output alternates 16'hFFFF and rom_data on each tick.
